mealy_pattern_gen: RTL

Serial bit-pattern transmitter that drives the single-bit `x` input of the team's Mealy sequence detectors. It latches a parallel pattern and shifts it out MSB-first, one bit per clock, for a programmable number of passes, then pulses `done`. It replaces hand-written `x` toggling in detector benches and serves as the serial source in on-chip self-test paths.

---
 rtl/mealy_pattern_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/mealy_pattern_gen.sv
// mealy_pattern_gen: latches a parallel pattern and shifts it out MSB-first for repeat_cnt+1 passes, then pulses done.
module mealy_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, pat_hold, pat_n;
    logic [BW-1:0] bit_cnt, cnt_n;
    logic [CNT_W-1:0] rep_left, rep_n;
    logic x_n, valid_n, busy_n, done_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            pat_hold <= '0;
            bit_cnt  <= '0;
            rep_left <= '0;
            x        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            pat_hold <= pat_n;
            bit_cnt  <= cnt_n;
            rep_left <= rep_n;
            x        <= x_n;
            valid    <= valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end
    // Outputs default to idle; each branch only raises what it drives.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        pat_n   = pat_hold;
        cnt_n   = bit_cnt;
        rep_n   = rep_left;
        x_n     = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                    pat_n   = pattern;
                    shreg_n = pattern;
                    rep_n   = repeat_cnt;
                    cnt_n   = '0;
                    x_n     = pattern[WIDTH-1];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (bit_cnt != LAST) begin
                    shreg_n = shreg << 1;
                    x_n     = shreg[WIDTH-2];
                    cnt_n   = bit_cnt + 1'b1;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else if (rep_left != '0) begin
                    shreg_n = pat_hold;
                    x_n     = pat_hold[WIDTH-1];
                    cnt_n   = '0;
                    rep_n   = rep_left - 1'b1;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b1;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
